// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the Data_Memory arbiter.
//   arb_state_e : arbiter FSM states (idle, port 0 owns memory, port 1 owns memory)
//   GNT_*       : one-hot grant encodings driven on grant_o
//   pick_port1  : winner selection for a request cycle in idle
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy0 = 2'd1,
    StBusy1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT0     = 2'b01;
  localparam logic [1:0] GNT1     = 2'b10;

  // Returns 1 when port 1 should win. On contention, round-robin hands the line
  // to whichever port did not win last; fixed priority always favours port 1.
  function automatic logic pick_port1(input logic en0,
                                      input logic en1,
                                      input logic round_robin,
                                      input logic last_port1);
    logic win1;
    if (en0 && en1) begin
      win1 = round_robin ? ~last_port1 : 1'b1;
    end else begin
      win1 = en1;
    end
    return win1;
  endfunction

endpackage

// File: rtl/dmem_arb_watchdog.sv
// Watchdog for the Data_Memory arbiter: counts busy cycles that pass without an
// ack and raises a sticky error once the count reaches TIMEOUT.
//   clk_i   : clock
//   rst_i   : asynchronous active-low reset
//   busy_i  : arbiter currently owns the memory port
//   ack_i   : memory acknowledged this cycle
//   clear_i : a new transaction is starting; restart the count
//   err_o   : sticky timeout flag, cleared only by reset
// TIMEOUT = 0 removes the counter and ties err_o low.
module dmem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  input  logic ack_i,
  input  logic clear_i,
  output logic err_o
);

  if (TIMEOUT == 0) begin : g_disabled

    logic unused_wd;
    assign unused_wd = ^{clk_i, rst_i, busy_i, ack_i, clear_i};
    assign err_o     = 1'b0;

  end else begin : g_enabled

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (busy_i && !ack_i && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Raise on the same edge the count lands on TIMEOUT.
      err_d = err_q | (cnt_d == CntMax);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign err_o = err_q;

  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single line-wide Data_Memory port.
// Port 0 is the instruction-cache refill path, port 1 the dcache refill /
// write-back path. One requester owns the memory from grant until mem_ack_i;
// the request is latched at grant so the requester may change its inputs
// while the transaction runs.
//   clk_i, rst_i                 : clock, asynchronous active-low reset
//   reqN_enable_i/_write_i       : request strobe (held until ack) and direction
//   reqN_addr_i/_data_i          : line address and write line
//   reqN_ack_o/_data_o           : completion pulse and read line (granted port only)
//   mem_enable_o/_write_o/_addr_o/_data_o : registered request to Data_Memory
//   mem_ack_i/_data_i            : Data_Memory completion and read line
//   grant_o                      : one-hot current owner, 00 when idle
//   err_o                        : sticky watchdog timeout
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ack_o,
  output logic [DATA_W-1:0] req0_data_o,

  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ack_o,
  output logic [DATA_W-1:0] req1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,

  output logic [1:0]        grant_o,
  output logic              err_o
);

  localparam logic RrEn = (ROUND_ROBIN != 0);

  arb_state_e state_q, state_d;

  logic              last_port1_q, last_port1_d;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;

  logic win1;
  logic load;

  // ---------------------------------------------------------------------------
  // Next-state and arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_port1_d = last_port1_q;
    load         = 1'b0;
    win1         = pick_port1(req0_enable_i, req1_enable_i, RrEn, last_port1_q);

    unique case (state_q)
      StIdle: begin
        // Requests are only looked at here; returning through idle after every
        // ack guarantees memory sees enable low for at least one cycle.
        if (req0_enable_i || req1_enable_i) begin
          load         = 1'b1;
          last_port1_d = win1;
          state_d      = win1 ? StBusy1 : StBusy0;
        end
      end
      StBusy0, StBusy1: begin
        if (mem_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      last_port1_q <= 1'b1;  // port 0 wins the first round-robin tie
    end else begin
      state_q      <= state_d;
      last_port1_q <= last_port1_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else if (load) begin
      mem_write_q <= win1 ? req1_write_i : req0_write_i;
      mem_addr_q  <= win1 ? req1_addr_i  : req0_addr_i;
      mem_data_q  <= win1 ? req1_data_i  : req0_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_enable_o = 1'b0;
    grant_o      = GNT_NONE;
    req0_ack_o   = 1'b0;
    req1_ack_o   = 1'b0;
    req0_data_o  = '0;
    req1_data_o  = '0;

    unique case (state_q)
      StBusy0: begin
        mem_enable_o = 1'b1;
        grant_o      = GNT0;
        req0_ack_o   = mem_ack_i;
        req0_data_o  = mem_data_i;
      end
      StBusy1: begin
        mem_enable_o = 1'b1;
        grant_o      = GNT1;
        req1_ack_o   = mem_ack_i;
        req1_data_o  = mem_data_i;
      end
      default: ;
    endcase
  end

  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  dmem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .busy_i  (state_q != StIdle),
    .ack_i   (mem_ack_i),
    .clear_i (load),
    .err_o   (err_o)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: u_rr (round-robin, default timeout) and u_fp (fixed
// priority, TIMEOUT=8) share the request and memory stimulus.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_enable, req0_write, req1_enable, req1_write;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          a_ack0, a_ack1, a_men, a_mwr, a_err;
  logic [DW-1:0] a_d0, a_d1, a_mdata;
  logic [AW-1:0] a_maddr;
  logic [1:0]    a_grant;

  logic          f_ack0, f_ack1, f_men, f_mwr, f_err;
  logic [DW-1:0] f_d0, f_d1, f_mdata;
  logic [AW-1:0] f_maddr;
  logic [1:0]    f_grant;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .ROUND_ROBIN (1), .TIMEOUT (64)
  ) u_rr (
    .clk_i (clk), .rst_i (rst_n),
    .req0_enable_i (req0_enable), .req0_write_i (req0_write),
    .req0_addr_i (req0_addr), .req0_data_i (req0_wdata),
    .req0_ack_o (a_ack0), .req0_data_o (a_d0),
    .req1_enable_i (req1_enable), .req1_write_i (req1_write),
    .req1_addr_i (req1_addr), .req1_data_i (req1_wdata),
    .req1_ack_o (a_ack1), .req1_data_o (a_d1),
    .mem_enable_o (a_men), .mem_write_o (a_mwr), .mem_addr_o (a_maddr),
    .mem_data_o (a_mdata), .mem_ack_i (mem_ack), .mem_data_i (mem_rdata),
    .grant_o (a_grant), .err_o (a_err)
  );

  dmem_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .ROUND_ROBIN (0), .TIMEOUT (8)
  ) u_fp (
    .clk_i (clk), .rst_i (rst_n),
    .req0_enable_i (req0_enable), .req0_write_i (req0_write),
    .req0_addr_i (req0_addr), .req0_data_i (req0_wdata),
    .req0_ack_o (f_ack0), .req0_data_o (f_d0),
    .req1_enable_i (req1_enable), .req1_write_i (req1_write),
    .req1_addr_i (req1_addr), .req1_data_i (req1_wdata),
    .req1_ack_o (f_ack1), .req1_data_o (f_d1),
    .mem_enable_o (f_men), .mem_write_o (f_mwr), .mem_addr_o (f_maddr),
    .mem_data_o (f_mdata), .mem_ack_i (mem_ack), .mem_data_i (mem_rdata),
    .grant_o (f_grant), .err_o (f_err)
  );

  typedef struct {
    logic       en0, en1, ack;
    logic [1:0] gnt;
    logic       men, ack0, ack1, d0, d1;
  } vec_t;

  function automatic vec_t mk(input logic en0, input logic en1, input logic ack,
                              input logic [1:0] gnt, input logic men, input logic ack0,
                              input logic ack1, input logic d0, input logic d1);
    vec_t v;
    v.en0 = en0; v.en1 = en1; v.ack = ack; v.gnt = gnt; v.men = men;
    v.ack0 = ack0; v.ack1 = ack1; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_idle();
    req0_enable = 1'b0; req1_enable = 1'b0;
    req0_write  = 1'b0; req1_write  = 1'b0;
    mem_ack     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requesters re-request until their quota is served; memory acks on the
  // second busy cycle. Records the owner of each transaction in order.
  task automatic run_seq(input bit fp, input int n0_in, input int n1_in,
                         output int owners[8], output int n_own, output int gap_err,
                         output bit expired);
    int         n0, n1, busy;
    logic [1:0] g, prevg;
    n0 = n0_in; n1 = n1_in; busy = 0; prevg = 2'b00;
    n_own = 0; gap_err = 0; expired = 1'b1;
    for (int k = 0; k < 8; k++) owners[k] = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      g = fp ? f_grant : a_grant;
      if (g != 2'b00 && prevg != 2'b00 && g != prevg) gap_err++;
      if (g != 2'b00 && prevg == 2'b00) begin
        if (n_own < 8) owners[n_own] = g[1] ? 1 : 0;
        n_own++;
        busy = 0;
      end
      if (g != 2'b00) busy++;
      mem_ack = (g != 2'b00) && (busy >= 2);
      if (mem_ack && g[0]) n0--;
      if (mem_ack && g[1]) n1--;
      req0_enable = (n0 > 0);
      req1_enable = (n1 > 0);
      prevg = g;
      if (n0 <= 0 && n1 <= 0) begin
        expired = 1'b0;
        break;
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[12];
    logic [DW-1:0] rd;
    logic [DW-1:0] line;
    logic [DW-1:0] exp_addr;
    int            owners[8];
    int            n_own, gap_err;
    bit            expired;
    logic          stray;

    rst_n = 1'b1;
    drive_idle();
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0; mem_rdata = '0;
    #1 rst_n = 1'b0;

    //                en0 en1 ack gnt    men a0 a1 d0 d1
    vecs[0]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 2'b00, 0, 0, 0, 0, 0);  // idle ack ignored; tie -> port 0
    vecs[2]  = mk(1, 1, 0, 2'b01, 1, 0, 0, 1, 0);
    vecs[3]  = mk(1, 1, 1, 2'b01, 1, 1, 0, 1, 0);
    vecs[4]  = mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 1, 2'b10, 1, 0, 1, 0, 1);  // port-0 request ignored while busy
    vecs[6]  = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 0);  // mandatory idle; tie -> port 0
    vecs[7]  = mk(0, 1, 1, 2'b01, 1, 1, 0, 1, 0);  // enable dropped, ack still forwarded
    vecs[8]  = mk(0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 2'b10, 1, 0, 0, 0, 1);
    vecs[10] = mk(0, 0, 1, 2'b10, 1, 0, 1, 0, 1);
    vecs[11] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);

    // Reset state
    #1;
    chk("rst_grant", DW'(a_grant), DW'(2'b00));
    chk("rst_men", DW'(a_men), '0);
    chk("rst_maddr", DW'(a_maddr), '0);
    chk("rst_err", DW'(a_err), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors on the round-robin instance
    req0_addr = 32'h0000_0100;
    req1_addr = 32'h0000_0200;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req0_enable = vecs[i].en0;
      req1_enable = vecs[i].en1;
      mem_ack     = vecs[i].ack;
      rd          = {8{32'hA5A5_0000 + 32'(i)}};
      mem_rdata   = rd;
      #1;
      chk($sformatf("v%0d_grant", i), DW'(a_grant), DW'(vecs[i].gnt));
      chk($sformatf("v%0d_men", i), DW'(a_men), DW'(vecs[i].men));
      chk($sformatf("v%0d_ack0", i), DW'(a_ack0), DW'(vecs[i].ack0));
      chk($sformatf("v%0d_ack1", i), DW'(a_ack1), DW'(vecs[i].ack1));
      chk($sformatf("v%0d_d0", i), a_d0, vecs[i].d0 ? rd : '0);
      chk($sformatf("v%0d_d1", i), a_d1, vecs[i].d1 ? rd : '0);
      if (vecs[i].men) begin
        exp_addr = (vecs[i].gnt == 2'b01) ? DW'(32'h100) : DW'(32'h200);
        chk($sformatf("v%0d_maddr", i), DW'(a_maddr), exp_addr);
      end
    end

    // Single read on port 0, ack after 10 cycles
    do_reset();
    @(negedge clk);
    req0_enable = 1'b1; req0_addr = 32'h0000_0020; req0_write = 1'b0;
    #1;
    chk("rd_men_before", DW'(a_men), '0);
    @(negedge clk);
    #1;
    chk("rd_men_latency", DW'(a_men), DW'(1'b1));
    chk("rd_grant", DW'(a_grant), DW'(2'b01));
    chk("rd_maddr", DW'(a_maddr), DW'(32'h20));
    chk("rd_mwr", DW'(a_mwr), '0);
    stray = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      #1;
      stray = stray | a_ack0 | a_ack1 | (a_grant != 2'b01);
    end
    chk("rd_no_early_ack", DW'(stray), '0);
    chk("rd_err_quiet", DW'(a_err), '0);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 256'h05;
    #1;
    chk("rd_ack0", DW'(a_ack0), DW'(1'b1));
    chk("rd_data0", a_d0, 256'h05);
    chk("rd_ack1", DW'(a_ack1), '0);
    chk("rd_data1", a_d1, '0);
    @(negedge clk);
    mem_ack = 1'b0; req0_enable = 1'b0;
    #1;
    chk("rd_grant_done", DW'(a_grant), DW'(2'b00));
    chk("rd_men_done", DW'(a_men), '0);
    chk("rd_ack0_done", DW'(a_ack0), '0);

    // Round-robin alternation, three transactions each
    do_reset();
    run_seq(1'b0, 3, 3, owners, n_own, gap_err, expired);
    chk("rr_expired", DW'(expired), '0);
    chk("rr_count", DW'(n_own), DW'(6));
    chk("rr_gap", DW'(gap_err), '0);
    for (int k = 0; k < 6; k++) chk($sformatf("rr_owner%0d", k), DW'(owners[k]), DW'(k % 2));

    // Fixed priority: port 1 keeps winning until it stops
    do_reset();
    run_seq(1'b1, 1, 3, owners, n_own, gap_err, expired);
    chk("fp_expired", DW'(expired), '0);
    chk("fp_count", DW'(n_own), DW'(4));
    chk("fp_gap", DW'(gap_err), '0);
    for (int k = 0; k < 4; k++) chk($sformatf("fp_owner%0d", k), DW'(owners[k]), DW'(k < 3 ? 1 : 0));

    // Port-1 write with request inputs changing during the transaction
    do_reset();
    line = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    req1_enable = 1'b1; req1_write = 1'b1; req1_addr = 32'h0000_0400; req1_wdata = line;
    @(negedge clk);
    #1;
    chk("wr_grant", DW'(a_grant), DW'(2'b10));
    chk("wr_mwr", DW'(a_mwr), DW'(1'b1));
    chk("wr_maddr", DW'(a_maddr), DW'(32'h400));
    chk("wr_mdata", a_mdata, line);
    req1_addr = 32'h0000_0999; req1_wdata = ~line; req1_write = 1'b0; req0_enable = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("wr_hold_grant", DW'(a_grant), DW'(2'b10));
    chk("wr_hold_mwr", DW'(a_mwr), DW'(1'b1));
    chk("wr_hold_maddr", DW'(a_maddr), DW'(32'h400));
    chk("wr_hold_mdata", a_mdata, line);
    mem_ack = 1'b1;
    #1;
    chk("wr_ack1", DW'(a_ack1), DW'(1'b1));
    chk("wr_ack0", DW'(a_ack0), '0);
    @(negedge clk);
    drive_idle();
    #1;
    chk("wr_men_done", DW'(a_men), '0);
    chk("wr_grant_done", DW'(a_grant), DW'(2'b00));

    // Watchdog: TIMEOUT=8 instance, memory never acks
    do_reset();
    @(negedge clk);
    req0_enable = 1'b1; req0_addr = 32'h0000_0040;
    @(posedge clk);  // grant edge
    repeat (7) @(posedge clk);
    #1;
    chk("wd_err_before", DW'(f_err), '0);
    @(posedge clk);
    #1;
    chk("wd_err_at8", DW'(f_err), DW'(1'b1));
    chk("wd_grant_held", DW'(f_grant), DW'(2'b01));
    req0_enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("wd_err_sticky", DW'(f_err), DW'(1'b1));
    chk("wd_grant_still", DW'(f_grant), DW'(2'b01));
    chk("wd_long_timeout_quiet", DW'(a_err), '0);
    do_reset();
    #1;
    chk("wd_err_cleared", DW'(f_err), '0);
    chk("wd_grant_cleared", DW'(f_grant), DW'(2'b00));

    // Reset in the middle of a port-0 transaction
    @(negedge clk);
    req0_enable = 1'b1; req0_addr = 32'h0000_0020;
    @(negedge clk);
    #1;
    chk("mr_grant", DW'(a_grant), DW'(2'b01));
    #2 rst_n = 1'b0;
    #1;
    chk("mr_men", DW'(a_men), '0);
    chk("mr_grant_rst", DW'(a_grant), DW'(2'b00));
    chk("mr_maddr", DW'(a_maddr), '0);
    mem_ack = 1'b1; mem_rdata = 256'h77; req0_enable = 1'b0;
    @(negedge clk);
    #1;
    chk("mr_ack0_in_rst", DW'(a_ack0), '0);
    rst_n = 1'b1;
    #1;
    chk("mr_ack0_after", DW'(a_ack0), '0);
    @(negedge clk);
    mem_ack = 1'b0; req0_enable = 1'b1; req0_addr = 32'h0000_0080;
    @(negedge clk);
    #1;
    chk("mr_regrant", DW'(a_grant), DW'(2'b01));
    chk("mr_regrant_addr", DW'(a_maddr), DW'(32'h80));
    mem_ack = 1'b1;
    #1;
    chk("mr_regrant_ack", DW'(a_ack0), DW'(1'b1));
    @(negedge clk);
    drive_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
